seq_mul5x3_ctrl: RTL and testbench
==================================

// Module: seq_mul5x3_ctrl
// PURPOSE
//  Sequential 5x3 unsigned multiplier. Shares one 5-bit ripple-carry adder
//  (lab4_2) across 3 shift-add iterations instead of the 2 adders used by the
//  array multiplier. Sits between a requester (start/done handshake) and the
//  shared adder. Trades 4 cycles of latency for half the adder area.
// PARAMETERS
//  A_W    5  multiplicand width. Fixed by the lab4_2 adder width; only 5 is legal.
//  B_W    3  multiplier width = iteration count. 3 is the supported value.
//  P_W    8  product width (A_W+B_W). Derived; do not override.
// PORTS
//  clk     in   1    rising-edge clock
//  reset   in   1    synchronous, active-high
//  start   in   1    request pulse; sampled only in IDLE or DONE
//  in_a    in   5    multiplicand; captured on the accepted start edge
//  in_b    in   3    multiplier; captured on the accepted start edge
//  busy    out  1    high while iterating (state ITER)
//  done    out  1    one-cycle pulse; out_m is valid from this cycle
//  out_m   out  8    product; held until the next accepted start or reset
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, busy=0, done=0, out_m=0,
//    internal regs=0. Reset has priority over everything, including mid-ITER
//    (the operation is abandoned and no done is issued).
//  - Internal registers:
//    - A_reg[4:0]
//    - P[8:0] = {carry, hi[4:0], lo[2:0]}
//    - cnt[1:0]
//  - FSM: IDLE -> ITER -> DONE -> IDLE.
//    - IDLE: if start=1, then A_reg<=in_a; P<={1'b0,5'b0,in_b}; cnt<=0;
//      go to ITER.
//    - ITER: the adder computes {cout,sum} = hi + (P[0] ? A_reg : 5'b0),
//      with cin=0. Then P<={1'b0,cout,sum,P[2:1]} (add, then shift right by 1).
//      cnt increments each cycle; after the ITER cycle with cnt==2, go to DONE.
//      start is ignored while in ITER.
//    - DONE: done=1 and out_m=P[7:0], both registered. Next state is IDLE.
//      If start=1 in DONE, the new operands are captured and the FSM goes
//      straight to ITER (back-to-back; out_m holds the old result until the
//      next DONE).
//  - Timing (start sampled at edge t): busy=1 for cycles t+1..t+3. At t+4,
//    done=1 for exactly one cycle and out_m is updated. Latency is 4 cycles;
//    throughput is one product per 4 cycles with back-to-back starts.
//  - Arithmetic: unsigned only. The 9-bit P holds the adder carry, so no
//    overflow is possible. Max result 31*7=217 fits in 8 bits.
//  - in_a and in_b may change freely after the start edge; only captured
//    values are used.
//  - busy and done are never high at the same time.
// STRUCTURE
//  - Shared include mul_defs.vh: state encodings (S_IDLE=2'd0, S_ITER=2'd1,
//    S_DONE=2'd2), A_W/B_W/P_W, ITER_LAST=2'd2.
//  - Sub-module: exactly one lab4_2 instance (5-bit ripple-carry adder, cin tied
//    to 0). No fullAdder or halfAdder is used directly.
//  - Partial-product gating uses bitwise AND with {5{P[0]}}.
//  - Everything else is one clocked always block plus next-state logic.
// TESTING
//  1. Reset, then start with in_a=31, in_b=7 -> busy for 3 cycles, done at t+4,
//     out_m=217 (8'hD9).
//  2. in_a=0, in_b=5 and in_a=21, in_b=0 -> out_m=0 for both, done still at t+4.
//  3. in_a=21, in_b=5 -> out_m=105. Change in_a/in_b at t+1 -> result is
//     unchanged.
//  4. Start with 13x6; pulse start again at t+2 with 3x3 -> the second start is
//     ignored; out_m=78 and only one done pulse.
//  5. Assert reset at t+2 during 31x7 -> next cycle busy=0, done=0, out_m=0, no
//     done pulse follows.
//  6. Start 13x6, then hold start=1 in the DONE cycle with 31x7 -> done at t+4
//     with out_m=78, then done at t+8 with out_m=217.
//  7. Sweep all 256 operand pairs -> out_m == in_a*in_b every time.

Source files
------------

// File: rtl/seq_mul5x3_ctrl_pkg.sv
// Shared constants for the sequential 5x3 shift-add multiplier: operand widths,
// FSM state encodings and the last iteration index.
package seq_mul5x3_ctrl_pkg;

  localparam int A_W = 5;
  localparam int B_W = 3;
  localparam int P_W = A_W + B_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] ITER_LAST = 2'd2;

endpackage

// File: rtl/seq_mul5x3_ctrl_adder.sv
// lab4_2: 5-bit ripple-carry adder shared by every shift-add iteration.
module lab4_2
  import seq_mul5x3_ctrl_pkg::*;
(
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  input  logic           cin,
  output logic [A_W-1:0] sum,
  output logic           cout
);

  logic carry;

  // NOTE: the carry ripples through a blocking variable inside one always_comb,
  // so each bit sees the carry produced by the bit below it in the same pass.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < A_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_mul5x3_ctrl.sv
// Sequential 5x3 unsigned multiplier: one shared 5-bit adder, three
// add-then-shift iterations, start/done handshake toward the requester.
module seq_mul5x3_ctrl
  import seq_mul5x3_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [A_W-1:0] in_a,
  input  logic [B_W-1:0] in_b,
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] out_m
);

  logic [1:0]     state;
  logic [1:0]     state_next;
  logic [A_W-1:0] a_reg;
  logic [P_W:0]   p;        // {carry, hi[4:0], lo[2:0]}
  logic [1:0]     cnt;
  logic [A_W-1:0] addend;
  logic [A_W-1:0] sum;
  logic           cout;
  logic [P_W:0]   p_iter;
  logic           accept;
  logic           last_iter;

  assign addend    = a_reg & {A_W{p[0]}};
  assign p_iter    = {1'b0, cout, sum, p[B_W-1:1]};
  assign accept    = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_iter = (state == S_ITER) && (cnt == ITER_LAST);

  lab4_2 u_adder (
    .a    (p[P_W-1:B_W]),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_ITER;
      S_ITER:  if (cnt == ITER_LAST) state_next = S_DONE;
      S_DONE:  state_next = start ? S_ITER : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous and wins over everything, so an operation in
  // flight is dropped without ever reaching DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_reg <= '0;
      p     <= '0;
      cnt   <= '0;
      out_m <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_reg <= in_a;
        p     <= {1'b0, {A_W{1'b0}}, in_b};
        cnt   <= '0;
      end else if (state == S_ITER) begin
        p   <= p_iter;
        cnt <= cnt + 2'd1;
      end
      // out_m only changes on entry to DONE, so it holds across back-to-back runs.
      if (last_iter) out_m <= p_iter[P_W-1:0];
    end
  end

  assign busy = (state == S_ITER);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_mul5x3_ctrl.sv
// Self-checking bench for seq_mul5x3_ctrl: directed handshake scenarios plus a
// shuffled sweep of all operand pairs against a plain a*b reference.
module tb_seq_mul5x3_ctrl;

  localparam int LATENCY = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] in_a;
  logic [2:0] in_b;
  logic       busy;
  logic       done;
  logic [7:0] out_m;

  int n_vec  = 0;
  int n_miss = 0;

  seq_mul5x3_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in_a  (in_a),
    .in_b  (in_b),
    .busy  (busy),
    .done  (done),
    .out_m (out_m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation. glitch_cyc (1..3) re-asserts start mid-run with other
  // operands; the reference says that request must be ignored.
  task automatic do_op(input logic [4:0] a, input logic [2:0] b, input int glitch_cyc,
                       input logic [4:0] ga, input logic [2:0] gb);
    int exp;
    exp   = int'(a) * int'(b);
    in_a  = a;
    in_b  = b;
    start = 1'b1;
    step();
    start = 1'b0;
    in_a  = 5'($urandom_range(0, 31));
    in_b  = 3'($urandom_range(0, 7));
    for (int c = 1; c < LATENCY; c++) begin
      check("busy_iter", int'(busy), 1);
      check("done_early", int'(done), 0);
      if (c == glitch_cyc) begin
        start = 1'b1;
        in_a  = ga;
        in_b  = gb;
      end
      step();
      start = 1'b0;
    end
    check("done_at_t4", int'(done), 1);
    check("busy_in_done", int'(busy), 0);
    check("product", int'(out_m), exp);
    step();
    check("done_one_cycle", int'(done), 0);
    check("busy_after", int'(busy), 0);
    check("product_hold", int'(out_m), exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[256];
    reset = 1'b1;
    start = 1'b0;
    in_a  = '0;
    in_b  = '0;
    step();
    step();
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out_m", int'(out_m), 0);
    reset = 1'b0;
    step();

    // Corner operands and mid-run operand changes.
    do_op(5'd31, 3'd7, 0, 5'd0, 3'd0);
    do_op(5'd0,  3'd5, 0, 5'd0, 3'd0);
    do_op(5'd21, 3'd0, 0, 5'd0, 3'd0);
    do_op(5'd21, 3'd5, 0, 5'd0, 3'd0);

    // A start during ITER is ignored: one result, one done pulse.
    do_op(5'd13, 3'd6, 2, 5'd3, 3'd3);
    for (int i = 0; i < 3; i++) begin
      check("no_second_done", int'(done), 0);
      check("no_second_busy", int'(busy), 0);
      step();
    end
    check("ignored_start_out_m", int'(out_m), 78);

    // Reset in the middle of an iteration abandons it.
    in_a  = 5'd31;
    in_b  = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_out_m", int'(out_m), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("abort_no_done", int'(done), 0);
    end

    // Back-to-back: start held in the DONE cycle launches the next product.
    in_a  = 5'd13;
    in_b  = 3'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (LATENCY - 1) step();
    check("b2b_done1", int'(done), 1);
    check("b2b_out1", int'(out_m), 78);
    in_a  = 5'd31;
    in_b  = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < LATENCY; c++) begin
      check("b2b_busy", int'(busy), 1);
      check("b2b_old_held", int'(out_m), 78);
      step();
    end
    check("b2b_done2", int'(done), 1);
    check("b2b_out2", int'(out_m), 217);
    step();
    check("b2b_done2_end", int'(done), 0);

    // Every operand pair, in shuffled order, with random gaps and glitches.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j        = $urandom_range(0, i);
      t        = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      logic [4:0] a;
      logic [2:0] b;
      a = 5'(order[i] / 8);
      b = 3'(order[i] % 8);
      do_op(a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
            5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
